// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver for packed BCD digits with frame-coherent snapshots.
// Optional macro SEG_BLANK_GUARD_EN keeps sel inactive for BLANK_CYCLES after each digit advance.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lzb,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  if (SCAN_DIV < 2 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_cfg
    $error("seg_scan_driver: SCAN_DIV must be >= 2 and BLANK_CYCLES < SCAN_DIV");
  end

  // Active-high a..g pattern; 0xA-0xE blank, 0xF dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] code);
    case (code)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hF:    return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] x);
    return x ^ {8{INV}};
  endfunction

  function automatic logic [NUM_DIGITS-1:0] sel_pol(input logic [NUM_DIGITS-1:0] x);
    return x ^ {NUM_DIGITS{INV}};
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] sh_digits_p0;
  logic [NUM_DIGITS-1:0]   sh_dp_p0;
  logic                    sh_lzb_p0;
  logic                    tick;
  logic                    wrap;
  logic                    guard_on;

  assign tick = en && (cnt_p0 == CNT_MAX);
  assign wrap = tick && (idx_p0 == IDX_MAX);

  // Stage p0: prescaler, digit index and frame snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0       <= '0;
      idx_p0       <= '0;
      sh_digits_p0 <= '0;
      sh_dp_p0     <= '0;
      sh_lzb_p0    <= 1'b0;
    end else if (tick) begin
      cnt_p0 <= '0;
      if (idx_p0 == IDX_MAX) begin
        idx_p0       <= '0;
        sh_digits_p0 <= digits;
        sh_dp_p0     <= dp;
        sh_lzb_p0    <= lzb;
      end else begin
        idx_p0 <= idx_p0 + IDX_W'(1);
      end
    end else if (en) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

`ifdef SEG_BLANK_GUARD_EN
  localparam int GRD_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  logic [GRD_W-1:0] guard_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      guard_p0 <= '0;
    end else if (tick) begin
      guard_p0 <= GRD_W'(BLANK_CYCLES);
    end else if (en && guard_p0 != '0) begin
      guard_p0 <= guard_p0 - GRD_W'(1);
    end
  end

  assign guard_on = (guard_p0 != '0);
`else
  assign guard_on = 1'b0;
`endif

  logic [3:0]            code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic                  run;
  logic [NUM_DIGITS-1:0] onehot;
  logic [7:0]            pattern;

  // A zero digit is blanked only while every digit above it is also a blanked zero.
  always_comb begin
    blank = '0;
    run   = sh_lzb_p0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      code[i] = sh_digits_p0[4*i +: 4];
    end
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run      = run && (code[i] == 4'd0);
      blank[i] = run;
    end
    onehot  = NUM_DIGITS'(1) << idx_p0;
    pattern = {sh_dp_p0[idx_p0], blank[idx_p0] ? 7'h00 : decode_bcd(code[idx_p0])};
  end

  // Stage p1: registered select, segments and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= sel_pol('0);
      seg        <= seg_pol('0);
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en) begin
        seg <= seg_pol(pattern);
        sel <= guard_on ? sel_pol('0) : sel_pol(onehot);
      end else begin
        seg <= seg_pol('0);
        sel <= sel_pol('0);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random stimulus against a counter-based reference model.
module tb_seg_scan_driver;

  localparam int N  = 6;
  localparam int SD = 4;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic        lzb;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_done;

  seg_scan_driver #(
    .NUM_DIGITS(N),
    .SCAN_DIV(SD),
    .SEG_ACTIVE_LOW(1),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .digits(digits),
    .dp(dp),
    .lzb(lzb),
    .sel(sel),
    .seg(seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Active-low display patterns for codes 0..F, dp bit off.
  localparam logic [7:0] LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF
  };

  // Model state: enabled cycles since reset plus the last frame snapshot.
  int          m_ecnt;
  logic [23:0] m_dig;
  logic [5:0]  m_dp;
  logic        m_lzb;

  function automatic logic [7:0] model_seg(input int i);
    logic [3:0] c;
    logic       blanked;
    logic [7:0] p;
    c       = m_dig[4*i +: 4];
    blanked = (i > 0) && m_lzb;
    for (int j = i; j < N; j++) if (m_dig[4*j +: 4] != 4'd0) blanked = 1'b0;
    p = blanked ? 8'hFF : LUT[c];
    if (m_dp[i]) p[7] = 1'b0;
    return p;
  endfunction

  task automatic cycle();
    logic [5:0] e_sel;
    logic [7:0] e_seg;
    logic       e_fd;
    int         slot;
    int         pos;
    e_sel = 6'h3F;
    e_seg = 8'hFF;
    e_fd  = 1'b0;
    if (!rst) begin
      slot = (m_ecnt / SD) % N;
      pos  = m_ecnt % SD;
      e_fd = en && ((m_ecnt % (SD * N)) == SD * N - 1);
      if (en) begin
        e_seg = model_seg(slot);
        e_sel = ~(6'b1 << slot);
`ifdef SEG_BLANK_GUARD_EN
        if (m_ecnt >= SD && pos < BC) e_sel = 6'h3F;
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("sel", 32'(sel), 32'(e_sel));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (rst) begin
      m_ecnt = 0;
      m_dig  = '0;
      m_dp   = '0;
      m_lzb  = 1'b0;
    end else if (en) begin
      if (e_fd) begin
        m_dig = digits;
        m_dp  = dp;
        m_lzb = lzb;
      end
      m_ecnt++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    m_ecnt = 0;
    m_dig  = '0;
    m_dp   = '0;
    m_lzb  = 1'b0;
    rst    = 1'b1;
    en     = 1'b0;
    digits = '0;
    dp     = '0;
    lzb    = 1'b0;
    run(3);
    rst = 1'b0;
    run(5);

    // Normal time display
    digits = 24'h235959;
    en     = 1'b1;
    run(60);

    // Leading-zero blanking
    digits = 24'h000105;
    lzb    = 1'b1;
    run(60);

    // Mid-frame input change must wait for the next snapshot
    digits = 24'h000001;
    lzb    = 1'b0;
    run(26);
    digits = 24'h000002;
    run(30);

    // Enable gap in the middle of a slot
    run(13);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(30);

    // Dash, blank code and dp on a zero digit
    digits = 24'h0B0F00;
    dp     = 6'b000001;
    run(50);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) digits = 24'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 6'($urandom);
      if ($urandom_range(0, 15) == 0) lzb = 1'($urandom);
      if ($urandom_range(0, 5) == 0) digits[23:12] = 12'h000;
      cycle();
    end
    rst = 1'b0;
    en  = 1'b1;
    run(48);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
